// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [XLEN_DEFAULT-1:0] DIV0_QUOT = '1;
    localparam logic [XLEN_DEFAULT-1:0] INT_MIN   = {1'b1, {(XLEN_DEFAULT - 1){1'b0}}};

    // Encoding matches funct3 of the OP opcode with funct7 = 0000001.
    typedef enum logic [2:0] {
        OpMul    = 3'b000,
        OpMulh   = 3'b001,
        OpMulhsu = 3'b010,
        OpMulhu  = 3'b011,
        OpDiv    = 3'b100,
        OpDivu   = 3'b101,
        OpRem    = 3'b110,
        OpRemu   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_if.sv
// Start/busy/done handshake between the core and the multiply/divide unit.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) ();

    logic            start;
    muldiv_op_e      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, op_a, op_b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output busy, done, result
    );

endinterface

// File: rtl/muldiv_sign_fix.sv
// Operand magnitude extraction and final sign correction for multiply and divide results.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  muldiv_op_e        op,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [XLEN-1:0]   mag_a,
    output logic [XLEN-1:0]   mag_b,
    output logic              neg_a,
    output logic              neg_b,
    input  muldiv_op_e        fix_op,
    input  logic              fix_neg_a,
    input  logic              fix_neg_b,
    input  logic [2*XLEN-1:0] raw,
    output logic [XLEN-1:0]   fixed
);

    logic              signed_a;
    logic              signed_b;
    logic              neg_res;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;

    always_comb begin
        signed_a = op inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
        signed_b = op inside {OpMul, OpMulh, OpDiv, OpRem};
        neg_a    = signed_a & a[XLEN-1];
        neg_b    = signed_b & b[XLEN-1];
        mag_a    = neg_a ? -a : a;
        mag_b    = neg_b ? -b : b;
    end

    // raw holds the unsigned product, or {remainder, quotient} for divides.
    always_comb begin
        neg_res = fix_neg_a ^ fix_neg_b;
        prod    = neg_res ? -raw : raw;
        quo     = raw[XLEN-1:0];
        rem     = raw[2*XLEN-1:XLEN];
        fixed   = '0;
        unique case (fix_op)
            OpMul:                      fixed = prod[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu:  fixed = prod[2*XLEN-1:XLEN];
            OpDiv, OpDivu:              fixed = neg_res ? -quo : quo;
            OpRem, OpRemu:              fixed = fix_neg_a ? -rem : rem;
            default:                    fixed = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle combinational one.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned CNT_W = 6
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);

    muldiv_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d, acc_step;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    muldiv_op_e        op_q, op_d;
    logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic [XLEN-1:0]   mag_a, mag_b, fixed, special_res;
    logic              neg_a, neg_b, idle, is_div, b_zero, ovf;
    muldiv_op_e        fix_op;
    logic [2*XLEN-1:0] fix_raw;
    logic [XLEN:0]     sum, shifted;
    logic [XLEN-1:0]   diff;
    logic              ge;

    assign idle   = (state_q == StIdle);
    assign fix_op = idle ? bus.funct3 : op_q;

    muldiv_sign_fix #(
        .XLEN (XLEN)
    ) u_sign_fix (
        .op        (bus.funct3),
        .a         (bus.op_a),
        .b         (bus.op_b),
        .mag_a     (mag_a),
        .mag_b     (mag_b),
        .neg_a     (neg_a),
        .neg_b     (neg_b),
        .fix_op    (fix_op),
        .fix_neg_a (idle ? neg_a : neg_a_q),
        .fix_neg_b (idle ? neg_b : neg_b_q),
        .raw       (fix_raw),
        .fixed     (fixed)
    );

    // acc_q is {hi, lo} of the product, or {remainder, quotient} while dividing.
    always_comb begin
        sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        shifted  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        ge       = (shifted >= {1'b0, opnd_q});
        diff     = shifted[XLEN-1:0] - opnd_q;
        if (op_q[2]) begin
            acc_step = {(ge ? diff : shifted[XLEN-1:0]), acc_q[XLEN-2:0], ge};
        end else begin
            acc_step = {sum, acc_q[XLEN-1:1]};
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    assign fix_raw   = idle ? fast_prod : acc_step;
`else
    assign fix_raw   = acc_step;
`endif

    assign is_div      = bus.funct3[2];
    assign b_zero      = (bus.op_b == '0);
    assign ovf         = ((bus.funct3 == OpDiv) || (bus.funct3 == OpRem)) &&
                         (bus.op_a == INT_MIN) && (bus.op_b == DIV0_QUOT);
    // funct3[1] separates REM/REMU from DIV/DIVU.
    assign special_res = b_zero ? (bus.funct3[1] ? bus.op_a : DIV0_QUOT)
                                : (bus.funct3[1] ? '0 : INT_MIN);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (!bus.flush && bus.start) begin
                    op_d    = bus.funct3;
                    neg_a_d = neg_a;
                    neg_b_d = neg_b;
                    cnt_d   = '0;
                    acc_d   = is_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
                    opnd_d  = is_div ? mag_b : mag_a;
                    if (is_div && (b_zero || ovf)) begin
                        result_d = special_res;
                        state_d  = StDone;
`ifdef MULDIV_FAST_MUL_EN
                    end else if (!is_div) begin
                        result_d = fixed;
                        state_d  = StDone;
`endif
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (bus.flush) begin
                    state_d = StIdle;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        result_d = fixed;
                        state_d  = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            op_q     <= OpMul;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            op_q     <= op_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = (state_q != StIdle);
    assign bus.done   = (state_q == StDone);
    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; honours MULDIV_FAST_MUL_EN for multiply latency.
module tb_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    muldiv_if #(.XLEN(32)) bus ();

    muldiv_unit #(
        .XLEN  (32),
        .CNT_W (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Start sampled at edge 0; latency is the cycle index in which done is first seen.
    task automatic do_op(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat, input bit scramble,
                         input string tag);
        int lat;
        lat = -1;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = op;
        bus.op_a   = a;
        bus.op_b   = b;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (c == 1) check({tag, "_busy1"}, 32'(bus.busy), 32'd1);
            if (scramble && c == 2) begin
                bus.op_a = 32'h1234_5678;
                bus.op_b = 32'd1;
            end
            if (bus.done) begin
                lat = c;
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, bus.result, exp_res);
        @(negedge clk);
        check({tag, "_idle"}, {30'd0, bus.done, bus.busy}, 32'd0);
    endtask

    initial begin
        int d1, d2;
        bit seen_done;
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = OpMul;
        bus.op_a   = '0;
        bus.op_b   = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", bus.result, 32'd0);
        rst_n = 1'b1;

        do_op(OpMul,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 1'b0, "mul");
        do_op(OpMulh,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, 1'b0, "mulh");
        do_op(OpMulhu,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, 1'b0, "mulhu");
        do_op(OpMulhsu, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, MUL_LAT, 1'b0, "mulhsu");
        do_op(OpMulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 1'b0, "mulhu_max");
        do_op(OpDiv,    32'hFFFF_FFEC, 32'd6,         32'hFFFF_FFFD, DIV_LAT, 1'b1, "div_scr");
        do_op(OpRem,    32'hFFFF_FFEC, 32'd6,         32'hFFFF_FFFE, DIV_LAT, 1'b0, "rem");
        do_op(OpDivu,   32'd20,        32'd6,         32'd3,         DIV_LAT, 1'b0, "divu");
        do_op(OpRemu,   32'd20,        32'd6,         32'd2,         DIV_LAT, 1'b0, "remu");
        do_op(OpDivu,   32'd5,         32'd0,         32'hFFFF_FFFF, 1,       1'b0, "divu_by0");
        do_op(OpDiv,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,       1'b0, "div_ovf");
        do_op(OpRem,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,       1'b0, "rem_ovf");
        do_op(OpRem,    32'd5,         32'd0,         32'd5,         1,       1'b0, "rem_by0");

        // Flush in cycle 10 of a divide: IDLE in cycle 11, no done, result kept.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = OpDiv;
        bus.op_a   = 32'd100;
        bus.op_b   = 32'd7;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (c == 10) bus.flush = 1'b1;
        end
        @(negedge clk);
        check("flush_idle", 32'(bus.busy), 32'd0);
        bus.flush = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done) seen_done = 1'b1;
        end
        check("flush_no_done", 32'(seen_done), 32'd0);
        check("flush_result", bus.result, 32'd5);

        // Asynchronous reset mid-RUN clears outputs immediately.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = OpDivu;
        bus.op_a   = 32'd1000;
        bus.op_b   = 32'd3;
        @(posedge clk);
        repeat (5) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done) seen_done = 1'b1;
        end
        check("arst_no_done", 32'(seen_done), 32'd0);

        // start held high: one op per IDLE visit, dones in cycles 33 and 67.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = OpDivu;
        bus.op_a   = 32'd20;
        bus.op_b   = 32'd6;
        @(posedge clk);
        d1 = -1;
        d2 = -1;
        for (int c = 1; c <= 67; c++) begin
            @(negedge clk);
            if (bus.done) begin
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
            if (c == 67) bus.start = 1'b0;
        end
        check("hold_first_done", 32'(d1), 32'd33);
        check("hold_second_done", 32'(d2), 32'd67);
        check("hold_result", bus.result, 32'd3);
        repeat (2) @(negedge clk);
        check("hold_idle", 32'(bus.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
